// File: rtl/instr_pkg.sv
// Shared types and field layout for the SPI instruction deserializer.
// Frame word layout, MSB first: {pkt_valid, opcode, key, text, dest}.
package instr_pkg;

  localparam int ADDRW_DEF   = 8;
  localparam int OPCODEW_DEF = 2;

  typedef enum logic {
    IDLE,
    RECV
  } state_e;

  function automatic int shift_w(input int aw, input int ow);
    return 1 + ow + 3 * aw;
  endfunction

  function automatic int text_lsb(input int aw);
    return aw;
  endfunction

  function automatic int key_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int op_lsb(input int aw);
    return 3 * aw;
  endfunction

  function automatic int vld_bit(input int aw, input int ow);
    return 3 * aw + ow;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with register-array head, level count and
// simultaneous push/pop (a push is accepted when full if a pop happens too).
module instr_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == LW'(DEPTH));
  assign level = lvl_q;
  assign dout  = mem_q[rd_q];

  // Next storage, pointers and level from accepted push/pop.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // Register FIFO state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/instr_deserializer_q.sv
// SPI instruction deserializer: oversampled receive, frame checking,
// FIFO queueing and valid/ready presentation of decoded fields.
module instr_deserializer_q
  import instr_pkg::*;
#(
  parameter int ADDRW        = ADDRW_DEF,
  parameter int OPCODEW      = OPCODEW_DEF,
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter bit DROP_INVALID = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_clk,
  input  logic                       mosi,
  input  logic                       cs_n,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic                       valid,
  output logic [OPCODEW-1:0]         opcode,
  output logic [ADDRW-1:0]           key_addr,
  output logic [ADDRW-1:0]           text_addr,
  output logic [ADDRW-1:0]           dest_addr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overrun,
  output logic                       frame_err,
  input  logic                       clear_err
);

  localparam int SHIFT_W = shift_w(ADDRW, OPCODEW);
  localparam int CNTW    = $clog2(SHIFT_W + 2);
  localparam int S       = SYNC_STAGES;
  localparam int VLD     = vld_bit(ADDRW, OPCODEW);
  localparam int OPL     = op_lsb(ADDRW);
  localparam int KEYL    = key_lsb(ADDRW);
  localparam int TXTL    = text_lsb(ADDRW);

  logic [S-1:0]       sck_q, sck_d;
  logic [S-1:0]       mosi_q, mosi_d;
  logic [S-1:0]       csn_q, csn_d;
  logic               sclk_rise, cs_fall, cs_rise, mosi_s;

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               ovr_q, ovr_d;
  logic               ferr_q, ferr_d;
  logic               push_req, set_ferr, set_ovr;

  logic [SHIFT_W-1:0] head;
  logic               f_empty, f_full, pop;

  // Shift async SPI pins through the synchroniser chains.
  always_comb begin
    sck_d  = {sck_q[S-2:0], spi_clk};
    mosi_d = {mosi_q[S-2:0], mosi};
    csn_d  = {csn_q[S-2:0], cs_n};
  end

  assign sclk_rise = sck_q[S-2] & ~sck_q[S-1];
  assign cs_fall   = ~csn_q[S-2] & csn_q[S-1];
  assign cs_rise   = csn_q[S-2] & ~csn_q[S-1];
  // mosi is stable around the SPI rising edge; take the older sample.
  assign mosi_s    = mosi_q[S-1];

  assign pop = ~f_empty & ready_in;

  // Frame FSM: shift bits while selected, judge frame length on deselect.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    set_ferr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = RECV;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNTW'(SHIFT_W)) begin
            push_req = ~(DROP_INVALID & ~shreg_q[VLD]);
          end else if (cnt_q != '0) begin
            set_ferr = 1'b1;
          end
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[SHIFT_W-2:0], mosi_s};
          if (cnt_q != CNTW'(SHIFT_W + 1)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    set_ovr = push_req & f_full & ~pop;
    ovr_d   = set_ovr | (ovr_q & ~clear_err);
    ferr_d  = set_ferr | (ferr_q & ~clear_err);
  end

  // Register synchronisers, FSM, shift register, counter and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q   <= '0;
      mosi_q  <= '0;
      csn_q   <= '1;
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  instr_fifo #(
    .WIDTH(SHIFT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_req),
    .din  (shreg_q),
    .pop  (pop),
    .dout (head),
    .empty(f_empty),
    .full (f_full),
    .level(fifo_level)
  );

  assign valid_out = ~f_empty;
  assign valid     = head[VLD];
  assign opcode    = head[OPL +: OPCODEW];
  assign key_addr  = head[KEYL +: ADDRW];
  assign text_addr = head[TXTL +: ADDRW];
  assign dest_addr = head[0 +: ADDRW];
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_instr_deserializer_q.sv
// Bench for instr_deserializer_q: directed + random SPI frames,
// scoreboard queue filled by a frame model, drained by a monitor.
module tb_instr_deserializer_q;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       ready_in = 1'b0;
  logic       clear_err = 1'b0;

  logic       v_o, vld, ovr, ferr;
  logic [1:0] op;
  logic [7:0] key, txt, dst;
  logic [2:0] lvl;

  logic       v1_o, vld1, ovr1, ferr1;
  logic [1:0] op1;
  logic [7:0] key1, txt1, dst1;
  logic [2:0] lvl1;

  instr_deserializer_q #(.DEPTH(DEPTH), .DROP_INVALID(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .mosi(mosi),
    .cs_n(cs_n), .ready_in(ready_in), .valid_out(v_o), .valid(vld),
    .opcode(op), .key_addr(key), .text_addr(txt), .dest_addr(dst),
    .fifo_level(lvl), .overrun(ovr), .frame_err(ferr),
    .clear_err(clear_err)
  );

  instr_deserializer_q #(.DEPTH(DEPTH), .DROP_INVALID(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .mosi(mosi),
    .cs_n(cs_n), .ready_in(1'b1), .valid_out(v1_o), .valid(vld1),
    .opcode(op1), .key_addr(key1), .text_addr(txt1), .dest_addr(dst1),
    .fifo_level(lvl1), .overrun(ovr1), .frame_err(ferr1),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] k;
    logic [7:0] t;
    logic [7:0] d;
  } ent_t;

  ent_t        exp_q[$];
  int          n_total = 0;
  int          n_bad = 0;
  bit          exp_ovr = 0;
  bit          exp_ferr = 0;
  int          exp1_pushes = 0;
  int          got1_pushes = 0;
  bit          rand_rdy = 0;
  bit          hold_prev = 0;
  logic [26:0] prev_data;

  logic [26:0] ia, ib, ic, id, inv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: a 27-bit frame queues its fields unless DEPTH are pending;
  // any other non-zero length is a framing error.
  task automatic model_frame(input logic [31:0] w, input int n);
    ent_t e;
    if (n == 27) begin
      e.v  = w[26];
      e.op = w[25:24];
      e.k  = w[23:16];
      e.t  = w[15:8];
      e.d  = w[7:0];
      if (w[26]) exp1_pushes++;
      if (exp_q.size() >= DEPTH) exp_ovr = 1;
      else exp_q.push_back(e);
    end else if (n != 0) begin
      exp_ferr = 1;
    end
  endtask

  task automatic send(input logic [31:0] w, input int n);
    cs_n = 1'b0;
    #40;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      #40 spi_clk = 1'b1;
      #40 spi_clk = 1'b0;
    end
    #40;
    model_frame(w, n);
    cs_n = 1'b1;
    #120;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    #10;
    clear_err = 1'b0;
    exp_ovr = 0;
    exp_ferr = 0;
    #10;
  endtask

  task automatic drain(input string nm);
    int i;
    ready_in = 1'b1;
    for (i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !v_o) break;
      #10;
    end
    chk({nm, "_drain"}, (i < 300), 1);
    chk({nm, "_lvl0"}, lvl, 0);
  endtask

  task automatic chk_flags(input string nm);
    chk({nm, "_ovr"}, ovr, exp_ovr);
    chk({nm, "_ferr"}, ferr, exp_ferr);
    chk({nm, "_ferr1"}, ferr1, exp_ferr);
    chk({nm, "_ovr1"}, ovr1, 0);
  endtask

  // Monitor: compare every popped head with the scoreboard.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (hold_prev) begin
        chk("hold_valid", v_o, 1);
        chk("hold_data", {vld, op, key, txt, dst}, prev_data);
      end
      if (v_o && ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", {vld, op, key, txt, dst},
              {e.v, e.op, e.k, e.t, e.d});
        end
      end
      hold_prev = v_o && !ready_in;
      prev_data = {vld, op, key, txt, dst};
      if (v1_o) begin
        got1_pushes++;
        chk("drop_vld", vld1, 1);
      end
    end else begin
      hold_prev = 0;
    end
  end

  // Random consumer back-pressure, driven just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [31:0] w;
    int          n;
    int          r;
    ia  = {1'b1, 2'b01, 8'hAA, 8'h55, 8'h0E};
    ib  = {1'b1, 2'b10, 8'h0F, 8'hF0, 8'h7C};
    ic  = {1'b1, 2'b11, 8'h5A, 8'hC3, 8'h12};
    id  = {1'b1, 2'b00, 8'h11, 8'h22, 8'h33};
    inv = {1'b0, 2'b01, 8'hAA, 8'h55, 8'h0E};

    @(posedge clk);
    #1;
    #40;
    rst_n = 1'b1;
    #10;
    chk("rst_valid_out", v_o, 0);
    chk("rst_fields", {vld, op, key, txt, dst}, 0);
    chk("rst_level", lvl, 0);
    chk_flags("rst");

    // Single frame delivered straight through.
    ready_in = 1'b1;
    send({5'd0, ia}, 27);
    drain("normal");
    chk_flags("normal");

    // Short frame aborted after 13 bits.
    send({5'd0, ib} >> 14, 13);
    chk("abort_level", lvl, 0);
    chk_flags("abort");
    pulse_clear();
    chk_flags("abort_clr");

    // Three frames queued behind a stalled consumer.
    ready_in = 1'b0;
    send({5'd0, ia}, 27);
    send({5'd0, ib}, 27);
    send({5'd0, ic}, 27);
    chk("queue_level", lvl, 3);
    chk("queue_valid", v_o, 1);
    drain("queue");
    chk_flags("queue");

    // DEPTH+1 frames: the last one is lost and flagged.
    ready_in = 1'b0;
    send({5'd0, ia}, 27);
    send({5'd0, ib}, 27);
    send({5'd0, ic}, 27);
    send({5'd0, id}, 27);
    send({5'd0, ib ^ 27'h00FFFF}, 27);
    chk("ovr_level", lvl, 4);
    chk("ovr_set", ovr, 1);
    chk_flags("ovr");
    drain("ovr");
    pulse_clear();
    chk_flags("ovr_clr");

    // 28-bit frame is too long.
    send(({5'd0, ia} << 1) | 32'd1, 28);
    chk("long_level", lvl, 0);
    chk("long_ferr", ferr, 1);
    chk_flags("long");
    pulse_clear();

    // pkt_valid=0 frame: kept by dut0, silently dropped by dut1.
    send({5'd0, inv}, 27);
    drain("inv");
    chk_flags("inv");
    chk("inv_drop_cnt", got1_pushes, exp1_pushes);

    // Reset in the middle of a frame, then a clean frame.
    cs_n = 1'b0;
    #40;
    for (int i = 26; i > 16; i--) begin
      mosi = ib[i];
      #40 spi_clk = 1'b1;
      #40 spi_clk = 1'b0;
    end
    rst_n = 1'b0;
    #30;
    cs_n = 1'b1;
    #30;
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovr = 0;
    exp_ferr = 0;
    #60;
    chk("midrst_level", lvl, 0);
    send({5'd0, ic}, 27);
    drain("midrst");
    chk_flags("midrst");

    // Random frames and lengths under random back-pressure.
    rand_rdy = 1;
    for (int k = 0; k < 30; k++) begin
      w = $urandom;
      r = $urandom_range(0, 9);
      if (r < 6) n = 27;
      else if (r == 6) n = 0;
      else if (r == 7) n = $urandom_range(1, 26);
      else n = $urandom_range(28, 31);
      send(w, n);
    end
    rand_rdy = 0;
    #20;
    drain("rand");
    chk_flags("rand");
    pulse_clear();
    chk_flags("rand_clr");
    chk("drop_cnt", got1_pushes, exp1_pushes);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
